// File: rtl/llc_pkg.sv
// Shared types and defaults for the LLC tag controller: MESI/op/FSM enums,
// default geometry, and address field extraction helpers.
package llc_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_SNOOP_INV = 2'd2,
    OP_SNOOP_RD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int LLC_ADDR_W   = 32;
  localparam int LLC_OFFSET_W = 6;
  localparam int LLC_INDEX_W  = 4;
  localparam int LLC_WAYS     = 4;

  // Extract a field of 'width' bits starting at bit 'lsb'; used to split an
  // address into its tag (lsb=OFFSET_W+INDEX_W) and index (lsb=OFFSET_W).
  function automatic logic [63:0] llc_addr_field(input logic [63:0] addr,
                                                 input int lsb,
                                                 input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [31:0] llc_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/llc_plru_tree.sv
// Tree-PLRU for one set: victim selection and next tree bits after an access.
// Nodes are heap-ordered (root 0, children 2n+1/2n+2); a 0 bit points left.
module llc_plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         i_bits,
  input  logic [$clog2(WAYS)-1:0] i_acc_way,
  output logic [$clog2(WAYS)-1:0] o_victim,
  output logic [WAYS-2:0]         o_bits_nxt
);

  localparam int WW = $clog2(WAYS);
  localparam int NI = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  int          w_vnode;
  int          w_vpath;
  logic        w_vbit;
  int          w_unode;
  logic        w_ubit;
  logic [WW-1:0] w_shift;

  // Follow the pointers from the root; the path bits spell the victim way.
  always_comb begin
    w_vnode = 0;
    w_vpath = 0;
    w_vbit  = 1'b0;
    for (int l = 0; l < WW; l++) begin
      w_vbit  = i_bits[NI'(w_vnode)];
      w_vpath = 2 * w_vpath + int'(w_vbit);
      w_vnode = 2 * w_vnode + 1 + int'(w_vbit);
    end
    o_victim = WW'(w_vpath);
  end

  // Walk the accessed way's path and flip each node to point away from it.
  always_comb begin
    o_bits_nxt = i_bits;
    w_unode    = 0;
    w_ubit     = 1'b0;
    w_shift    = '0;
    for (int l = 0; l < WW; l++) begin
      w_shift = i_acc_way >> (WW - 1 - l);
      w_ubit  = w_shift[0];
      o_bits_nxt[NI'(w_unode)] = ~w_ubit;
      w_unode = 2 * w_unode + 1 + int'(w_ubit);
    end
  end

endmodule

// File: rtl/llc_tag_ctrl.sv
// Set-associative LLC tag controller with MESI state and tree-PLRU allocation.
// Optional hit/miss/evict/writeback counters when LLC_STATS_EN is defined.
module llc_tag_ctrl
  import llc_pkg::*;
#(
  parameter int ADDR_W   = LLC_ADDR_W,
  parameter int OFFSET_W = LLC_OFFSET_W,
  parameter int INDEX_W  = LLC_INDEX_W,
  parameter int WAYS     = LLC_WAYS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    rsp_valid,
  output logic                    rsp_hit,
  output logic [$clog2(WAYS)-1:0] rsp_way,
  output logic [1:0]              rsp_mesi,
  output logic                    rsp_evict,
  output logic                    rsp_wb,
  output logic [ADDR_W-1:0]       rsp_victim_addr,
  output logic [1:0]              dbg_state
`ifdef LLC_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses,
  output logic [31:0]             stat_evicts,
  output logic [31:0]             stat_wbs
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WW    = $clog2(WAYS);

  // Handshake: a request is taken on any clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE. The response is a single-cycle rsp_valid
  // pulse with no backpressure; rsp_* are zero whenever rsp_valid is low.

  state_e              r_state;
  state_e              w_state_nxt;
  op_e                 r_op;
  logic [ADDR_W-1:0]   r_addr;

  mesi_e               r_mesi [SETS][WAYS];
  logic [TAG_W-1:0]    r_tag  [SETS][WAYS];
  logic [WAYS-2:0]     r_plru [SETS];

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic                w_accept;

  logic                w_hit;
  logic [WW-1:0]       w_hit_way;
  logic                w_inv_found;
  logic [WW-1:0]       w_inv_way;
  logic [WW-1:0]       w_plru_victim;
  logic [WW-1:0]       w_sel_way;
  logic [WAYS-2:0]     w_plru_nxt;

  logic                r_hit;
  logic [WW-1:0]       r_way;
  mesi_e               r_old_mesi;
  logic [TAG_W-1:0]    r_old_tag;

  logic                w_wr_line;
  logic                w_touch;
  mesi_e               w_new_mesi;
  logic                w_rsp_hit;
  logic [WW-1:0]       w_rsp_way;
  mesi_e               w_rsp_mesi;
  logic                w_rsp_evict;
  logic                w_rsp_wb;
  logic [ADDR_W-1:0]   w_rsp_vaddr;

  logic                r_rsp_hit;
  logic [WW-1:0]       r_rsp_way;
  mesi_e               r_rsp_mesi;
  logic                r_rsp_evict;
  logic                r_rsp_wb;
  logic [ADDR_W-1:0]   r_rsp_vaddr;

  assign w_tag    = TAG_W'(llc_addr_field(64'(r_addr), OFFSET_W + INDEX_W, TAG_W));
  assign w_idx    = INDEX_W'(llc_addr_field(64'(r_addr), OFFSET_W, INDEX_W));
  assign w_accept = req_valid && req_ready;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = ST_RESP;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Scan downward so the lowest-numbered invalid way wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mesi[w_idx][w] == MESI_I) begin
        w_inv_found = 1'b1;
        w_inv_way   = WW'(w);
      end else if (r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  assign w_sel_way = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_plru_victim);

  llc_plru_tree #(.WAYS(WAYS)) u_plru (
    .i_bits     (r_plru[w_idx]),
    .i_acc_way  (r_way),
    .o_victim   (w_plru_victim),
    .o_bits_nxt (w_plru_nxt)
  );

  always_comb begin
    w_wr_line   = 1'b0;
    w_touch     = 1'b0;
    w_new_mesi  = r_old_mesi;
    w_rsp_hit   = r_hit;
    w_rsp_way   = r_way;
    w_rsp_mesi  = MESI_I;
    w_rsp_evict = 1'b0;
    w_rsp_wb    = 1'b0;
    w_rsp_vaddr = '0;
    case (r_op)
      OP_READ, OP_WRITE: begin
        w_touch   = 1'b1;
        w_wr_line = 1'b1;
        if (r_hit) begin
          w_new_mesi = (r_op == OP_WRITE) ? MESI_M : r_old_mesi;
        end else begin
          w_new_mesi  = (r_op == OP_WRITE) ? MESI_M : MESI_E;
          w_rsp_evict = (r_old_mesi != MESI_I);
          w_rsp_wb    = (r_old_mesi == MESI_M);
          if (w_rsp_evict) w_rsp_vaddr = {r_old_tag, w_idx, {OFFSET_W{1'b0}}};
        end
        w_rsp_mesi = w_new_mesi;
      end
      default: begin
        // Snoops only act on a hit and never disturb the replacement order.
        if (r_hit) begin
          w_wr_line  = 1'b1;
          w_new_mesi = (r_op == OP_SNOOP_INV) ? MESI_I : MESI_S;
          w_rsp_wb   = (r_old_mesi == MESI_M);
          if (w_rsp_wb) w_rsp_vaddr = {w_tag, w_idx, {OFFSET_W{1'b0}}};
          w_rsp_mesi = w_new_mesi;
        end else begin
          w_rsp_way = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_mesi[s][w] <= MESI_I;
          r_tag[s][w]  <= '0;
        end
        r_plru[s] <= '0;
      end
    end else if (r_state == ST_UPDATE) begin
      if (w_wr_line) begin
        r_mesi[w_idx][r_way] <= w_new_mesi;
        r_tag[w_idx][r_way]  <= w_tag;
      end
      if (w_touch) r_plru[w_idx] <= w_plru_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= OP_READ;
      r_addr      <= '0;
      r_hit       <= 1'b0;
      r_way       <= '0;
      r_old_mesi  <= MESI_I;
      r_old_tag   <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_way   <= '0;
      r_rsp_mesi  <= MESI_I;
      r_rsp_evict <= 1'b0;
      r_rsp_wb    <= 1'b0;
      r_rsp_vaddr <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= op_e'(req_op);
        r_addr <= req_addr;
      end
      if (r_state == ST_LOOKUP) begin
        r_hit      <= w_hit;
        r_way      <= w_sel_way;
        r_old_mesi <= r_mesi[w_idx][w_sel_way];
        r_old_tag  <= r_tag[w_idx][w_sel_way];
      end
      if (r_state == ST_UPDATE) begin
        r_rsp_hit   <= w_rsp_hit;
        r_rsp_way   <= w_rsp_way;
        r_rsp_mesi  <= w_rsp_mesi;
        r_rsp_evict <= w_rsp_evict;
        r_rsp_wb    <= w_rsp_wb;
        r_rsp_vaddr <= w_rsp_vaddr;
      end
    end
  end

  assign rsp_valid       = (r_state == ST_RESP);
  assign rsp_hit         = rsp_valid & r_rsp_hit;
  assign rsp_way         = rsp_valid ? r_rsp_way : '0;
  assign rsp_mesi        = rsp_valid ? r_rsp_mesi : MESI_I;
  assign rsp_evict       = rsp_valid & r_rsp_evict;
  assign rsp_wb          = rsp_valid & r_rsp_wb;
  assign rsp_victim_addr = rsp_valid ? r_rsp_vaddr : '0;

`ifdef LLC_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;
  logic [31:0] r_stat_evicts;
  logic [31:0] r_stat_wbs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_evicts <= '0;
      r_stat_wbs    <= '0;
    end else if (r_state == ST_RESP && (r_op == OP_READ || r_op == OP_WRITE)) begin
      if (r_rsp_hit) r_stat_hits   <= llc_sat_inc(r_stat_hits);
      else           r_stat_misses <= llc_sat_inc(r_stat_misses);
      if (r_rsp_evict) r_stat_evicts <= llc_sat_inc(r_stat_evicts);
      if (r_rsp_wb)    r_stat_wbs    <= llc_sat_inc(r_stat_wbs);
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
  assign stat_evicts = r_stat_evicts;
  assign stat_wbs    = r_stat_wbs;
`endif

endmodule

// File: tb/tb_llc_tag_ctrl.sv
// Bench for llc_tag_ctrl: directed scenarios plus randomized traffic checked
// against a set/way/tree array model of the cache.
module tb_llc_tag_ctrl;

  localparam int EW = 39;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic [1:0]  rsp_mesi;
  logic        rsp_evict;
  logic        rsp_wb;
  logic [31:0] rsp_victim_addr;
  logic [1:0]  dbg_state;
`ifdef LLC_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
  logic [31:0] stat_evicts;
  logic [31:0] stat_wbs;
`endif

  llc_tag_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .rsp_valid       (rsp_valid),
    .rsp_hit         (rsp_hit),
    .rsp_way         (rsp_way),
    .rsp_mesi        (rsp_mesi),
    .rsp_evict       (rsp_evict),
    .rsp_wb          (rsp_wb),
    .rsp_victim_addr (rsp_victim_addr),
    .dbg_state       (dbg_state)
`ifdef LLC_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_evicts     (stat_evicts),
    .stat_wbs        (stat_wbs)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  logic        last_hit;
  logic [1:0]  last_way;
  logic [1:0]  last_mesi;
  logic        last_evict;
  logic        last_wb;
  logic [31:0] last_vaddr;

  // reference model: state (0=I,1=S,2=E,3=M), tag, and PLRU tree per set
  int          m_st   [16][4];
  logic [21:0] m_tag  [16][4];
  bit          m_tree [16][3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_st[s][w]  = 0;
        m_tag[s][w] = '0;
      end
      for (int n = 0; n < 3; n++) m_tree[s][n] = 1'b0;
    end
  endtask

  function automatic int plru_victim(input int s);
    int node;
    node = 0;
    while (node < 3) node = 2 * node + 1 + int'(m_tree[s][node]);
    return node - 3;
  endfunction

  task automatic plru_touch(input int s, input int way);
    int n, p;
    n = way + 3;
    while (n > 0) begin
      p = (n - 1) / 2;
      m_tree[s][p] = (n == 2 * p + 1);
      n = p;
    end
  endtask

  task automatic model_access(input logic [1:0] op, input logic [31:0] addr);
    int s, hw, way, mesi;
    logic [21:0] t;
    logic hit, ev, wb, found;
    logic [31:0] va;
    t = addr[31:10];
    s = int'(addr[9:6]);
    hw = -1;
    for (int w = 0; w < 4; w++)
      if (m_st[s][w] != 0 && m_tag[s][w] == t) hw = w;
    hit = (hw >= 0);
    ev = 1'b0; wb = 1'b0; va = '0; way = 0; mesi = 0;
    if (op == 2'd0 || op == 2'd1) begin
      if (hit) begin
        way = hw;
        if (op == 2'd1) m_st[s][hw] = 3;
      end else begin
        found = 1'b0;
        for (int w = 0; w < 4; w++)
          if (!found && m_st[s][w] == 0) begin
            found = 1'b1;
            way = w;
          end
        if (!found) way = plru_victim(s);
        ev = (m_st[s][way] != 0);
        wb = (m_st[s][way] == 3);
        if (ev) va = {m_tag[s][way], addr[9:6], 6'b0};
        m_st[s][way]  = (op == 2'd1) ? 3 : 2;
        m_tag[s][way] = t;
      end
      mesi = m_st[s][way];
      plru_touch(s, way);
    end else if (hit) begin
      way = hw;
      wb  = (m_st[s][hw] == 3);
      if (wb) va = {addr[31:6], 6'b0};
      m_st[s][hw] = (op == 2'd2) ? 0 : 1;
      mesi = m_st[s][hw];
    end
    exp_q.push_back({hit, 2'(way), 2'(mesi), ev, wb, va});
  endtask

  // driver: issue one request, then wait for and score its response
  task automatic send(input logic [1:0] op, input logic [31:0] addr);
    int n;
    logic [EW-1:0] e;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    model_access(op, addr);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("ready_busy", req_ready, 0);
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 3);
    e = exp_q.pop_front();
    if (rsp_valid) begin
      check("rsp_hit",   rsp_hit,         e[38]);
      check("rsp_way",   rsp_way,         e[37:36]);
      check("rsp_mesi",  rsp_mesi,        e[35:34]);
      check("rsp_evict", rsp_evict,       e[33]);
      check("rsp_wb",    rsp_wb,          e[32]);
      check("rsp_vaddr", rsp_victim_addr, e[31:0]);
    end else begin
      check("rsp_valid", rsp_valid, 1);
    end
    last_hit   = rsp_hit;
    last_way   = rsp_way;
    last_mesi  = rsp_mesi;
    last_evict = rsp_evict;
    last_wb    = rsp_wb;
    last_vaddr = rsp_victim_addr;
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
    check("idle_fields", {rsp_hit, rsp_way, rsp_mesi, rsp_evict, rsp_wb, rsp_victim_addr}, 0);
    check("ready_idle", req_ready, 1);
  endtask

  task automatic reset_in_update();
    int n_rsp;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_addr  = 32'h0000_1440;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("in_update", dbg_state, 2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_rsp = 0;
    repeat (5) begin
      if (rsp_valid) n_rsp++;
      @(negedge clk);
    end
    check("rst_no_rsp", n_rsp, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [1:0] op;
    logic [31:0] addr;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 2'd0;
    req_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", req_ready, 1);
    check("reset_state", dbg_state, 0);
    check("reset_rsp", {rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_evict, rsp_wb, rsp_victim_addr}, 0);
    rst_n = 1'b1;

    send(2'd0, 32'h0000_1040);
    check("tp_first_hit", last_hit, 0);
    check("tp_first_way", last_way, 0);
    check("tp_first_mesi", last_mesi, 2);
    check("tp_first_evict", last_evict, 0);
    send(2'd0, 32'h0000_1040);
    check("tp_reread_hit", last_hit, 1);
    send(2'd1, 32'h0000_1040);
    check("tp_write_mesi", last_mesi, 3);

    send(2'd0, 32'h0000_1440);
    send(2'd0, 32'h0000_1840);
    send(2'd0, 32'h0000_1C40);
    send(2'd0, 32'h0000_1040);
    send(2'd0, 32'h0000_2040);
    check("tp_fill_evict", last_evict, 1);
    check("tp_fill_wb", last_wb, 0);

    send(2'd0, 32'h0000_1440);
    send(2'd0, 32'h0000_1C40);
    send(2'd1, 32'h0000_2440);
    check("tp_wbev_way", last_way, 0);
    check("tp_wbev_evict", last_evict, 1);
    check("tp_wbev_wb", last_wb, 1);
    check("tp_wbev_vaddr", last_vaddr, 32'h0000_1040);
    check("tp_wbev_mesi", last_mesi, 3);

    send(2'd3, 32'h0000_2440);
    check("tp_snrd_hit", last_hit, 1);
    check("tp_snrd_mesi", last_mesi, 1);
    check("tp_snrd_wb", last_wb, 1);
    check("tp_snrd_vaddr", last_vaddr, 32'h0000_2440);
    send(2'd2, 32'h0000_2440);
    check("tp_sninv_mesi", last_mesi, 0);
    check("tp_sninv_wb", last_wb, 0);
    send(2'd2, 32'h0000_3040);
    check("tp_sninv_miss", last_hit, 0);
    send(2'd0, 32'h0000_1440);
    check("tp_after_miss_hit", last_hit, 1);

    reset_in_update();
    send(2'd0, 32'h0000_1440);
    check("tp_post_rst_hit", last_hit, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
      addr = {22'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      send(op, addr);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
